code_rom_arbiter: RTL



---
 rtl/code_rom_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/code_rom_arbiter.sv
// code_rom_arbiter: lets the target MCU fetch port and the debug supervisor
// fetch port share one single-port, fixed-latency code ROM. One fetch is in
// flight at a time. Each completed fetch returns a one-cycle ready pulse. A
// saturating counter records the cycles in which a target fetch is stalled.
module code_rom_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ROM_LATENCY = 2
) (
  input  logic                  sysclk,
  input  logic                  sysreset,
  input  logic                  tg_req,
  input  logic [ADDR_WIDTH-1:0] tg_addr,
  output logic [DATA_WIDTH-1:0] tg_data,
  output logic                  tg_ready,
  input  logic                  sv_req,
  input  logic [ADDR_WIDTH-1:0] sv_addr,
  output logic [DATA_WIDTH-1:0] sv_data,
  output logic                  sv_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  stall_clr,
  output logic [15:0]           tg_stall_count
);

  // The latency counter only ever holds ROM_LATENCY-1 down to 0.
  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Requester encoding used by owner and last_grant.
  localparam logic PORT_TG = 1'b0;
  localparam logic PORT_SV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_grant;
  logic             grant_any;
  logic             grant_sv;

  // Grant decision: a single requester wins outright; on a tie the port not
  // served last time wins, so continuous contention alternates.
  always_comb begin
    grant_any = tg_req | sv_req;
    if (tg_req && sv_req) begin
      grant_sv = (last_grant == PORT_TG);
    end else if (sv_req) begin
      grant_sv = 1'b1;
    end else begin
      grant_sv = 1'b0;
    end
  end

  // Fetch sequencer: grant in IDLE, count the ROM latency in WAIT, then spend
  // one cycle in DONE while the ready pulse is visible.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state      <= ST_IDLE;
      cnt        <= CNT_ZERO;
      owner      <= PORT_TG;
      last_grant <= PORT_TG;
      mem_addr   <= {ADDR_WIDTH{1'b0}};
      mem_rd     <= 1'b0;
      tg_data    <= {DATA_WIDTH{1'b0}};
      sv_data    <= {DATA_WIDTH{1'b0}};
      tg_ready   <= 1'b0;
      sv_ready   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tg_ready <= 1'b0;
          sv_ready <= 1'b0;
          if (grant_any) begin
            // Address is latched here only; later changes are ignored.
            mem_addr   <= grant_sv ? sv_addr : tg_addr;
            mem_rd     <= 1'b1;
            owner      <= grant_sv;
            last_grant <= grant_sv;
            cnt        <= CNT_LOAD;
            state      <= ST_WAIT;
          end else begin
            mem_rd <= 1'b0;
          end
        end
        ST_WAIT: begin
          mem_rd <= 1'b0;
          if (cnt == CNT_ZERO) begin
            state <= ST_DONE;
            // A requester that let go of req has abandoned the fetch: its
            // data register and ready stay untouched.
            if (owner == PORT_SV) begin
              if (sv_req) begin
                sv_data  <= mem_data;
                sv_ready <= 1'b1;
              end
            end else begin
              if (tg_req) begin
                tg_data  <= mem_data;
                tg_ready <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_DONE: begin
          // No grant here, so the two ready pulses can never touch.
          tg_ready <= 1'b0;
          sv_ready <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          mem_rd   <= 1'b0;
          tg_ready <= 1'b0;
          sv_ready <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where the target waits; clear wins over count.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      tg_stall_count <= 16'h0000;
    end else if (stall_clr) begin
      tg_stall_count <= 16'h0000;
    end else if (tg_req && !tg_ready && (tg_stall_count != 16'hFFFF)) begin
      tg_stall_count <= tg_stall_count + 16'h0001;
    end
  end

endmodule
